// File: rtl/data_path.sv
// Mini-SRC single-bus datapath: GPRs, PC/IR/MAR/MDR/Y/Z/HI/LO, CON flop, I/O ports, ALU, 512x32 RAM.
// Every load strobe takes effect on the next rising clock edge. Define EXT_MEM_EN to take MDR reads from Mdatain instead of the internal RAM.

module reg32 (
    input  logic        clock,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);
    logic [31:0] BusMuxIn;

    always_ff @(posedge clock) begin
        if (clear)     BusMuxIn <= '0;
        else if (load) BusMuxIn <= d;
    end

    assign q = BusMuxIn;
endmodule

module pc_reg (
    input  logic        clock,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);
    logic [31:0] newPC;

    always_ff @(posedge clock) begin
        if (clear)     newPC <= '0;
        else if (load) newPC <= d;
    end

    assign q = newPC;
endmodule

module data_path #(
    parameter int    MEM_DEPTH     = 512,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout,
    input  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin,
    input  logic        IncPC, Read, Write,
    input  logic        Gra, Grb, Grc,
    input  logic [4:0]  opcode,
    input  logic [8:0]  Address,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPortData,
    output logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    output logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    output logic        CON_out,
    output logic [31:0] OutPortData
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [4:0] OP_ADD  = 5'b00011, OP_ADD2 = 5'b01100, OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101, OP_AND2 = 5'b01101, OP_OR   = 5'b00110;
    localparam logic [4:0] OP_OR2  = 5'b01110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [31:0] bus, pc_val, c_sign, r_bus, mem_rdata;
    logic [31:0] r_val [16];
    logic [31:0] ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, outport_q, outport_d;
    logic [63:0] z_q, z_d, alu;
    logic        con_q, con_d, cond;
    logic [3:0]  reg_idx;
    logic [15:0] r_sel, r_out, r_in;

    pc_reg PC_inst (.clock(clock), .clear(clear), .load(PCin), .d(bus), .q(pc_val));

    reg32 r0  (.clock(clock), .clear(clear), .load(r_in[0]),  .d(bus), .q(r_val[0]));
    reg32 r1  (.clock(clock), .clear(clear), .load(r_in[1]),  .d(bus), .q(r_val[1]));
    reg32 r2  (.clock(clock), .clear(clear), .load(r_in[2]),  .d(bus), .q(r_val[2]));
    reg32 r3  (.clock(clock), .clear(clear), .load(r_in[3]),  .d(bus), .q(r_val[3]));
    reg32 r4  (.clock(clock), .clear(clear), .load(r_in[4]),  .d(bus), .q(r_val[4]));
    reg32 r5  (.clock(clock), .clear(clear), .load(r_in[5]),  .d(bus), .q(r_val[5]));
    reg32 r6  (.clock(clock), .clear(clear), .load(r_in[6]),  .d(bus), .q(r_val[6]));
    reg32 r7  (.clock(clock), .clear(clear), .load(r_in[7]),  .d(bus), .q(r_val[7]));
    reg32 r8  (.clock(clock), .clear(clear), .load(r_in[8]),  .d(bus), .q(r_val[8]));
    reg32 r9  (.clock(clock), .clear(clear), .load(r_in[9]),  .d(bus), .q(r_val[9]));
    reg32 r10 (.clock(clock), .clear(clear), .load(r_in[10]), .d(bus), .q(r_val[10]));
    reg32 r11 (.clock(clock), .clear(clear), .load(r_in[11]), .d(bus), .q(r_val[11]));
    reg32 r12 (.clock(clock), .clear(clear), .load(r_in[12]), .d(bus), .q(r_val[12]));
    reg32 r13 (.clock(clock), .clear(clear), .load(r_in[13]), .d(bus), .q(r_val[13]));
    reg32 r14 (.clock(clock), .clear(clear), .load(r_in[14]), .d(bus), .q(r_val[14]));
    reg32 r15 (.clock(clock), .clear(clear), .load(r_in[15]), .d(bus), .q(r_val[15]));

    always_comb begin
        reg_idx = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
        r_sel   = 16'b1 << reg_idx;
        r_out   = (Rout | BAout) ? r_sel : 16'h0;
        r_in    = Rin ? r_sel : 16'h0;
        c_sign  = {{13{ir_q[18]}}, ir_q[18:0]};
        // Base-address reads treat R0 as a literal zero; plain Rout still sees R0.
        r_bus   = (BAout && !Rout && reg_idx == 4'd0) ? 32'h0 : r_val[reg_idx];
    end

    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out} = r_out[15:8];
    assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out}       = r_out[7:0];

    always_comb begin
        if      (MDRout)         bus = mdr_q;
        else if (Zlowout)        bus = z_q[31:0];
        else if (Zhighout)       bus = z_q[63:32];
        else if (PCout)          bus = pc_val;
        else if (HIout)          bus = hi_q;
        else if (LOout)          bus = lo_q;
        else if (Yout)           bus = y_q;
        else if (InPortout)      bus = InPortData;
        else if (Cout)           bus = c_sign;
        else if (Rout | BAout)   bus = r_bus;
        else                     bus = 32'h0;
    end

    logic [4:0]         sh;
    logic [5:0]         sh_inv;
    logic [31:0]        alu_lo;
    logic signed [31:0] quo, rem;
    logic signed [63:0] prod;

    always_comb begin
        sh     = bus[4:0];
        sh_inv = 6'd32 - {1'b0, sh};
        quo    = '0;
        rem    = '0;
        if (bus != 32'h0) begin
            quo = $signed(y_q) / $signed(bus);
            rem = $signed(y_q) % $signed(bus);
        end
        prod   = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
        alu_lo = bus;
        if (IncPC) begin
            alu_lo = bus + 32'd1;
        end else begin
            case (opcode)
                OP_ADD, OP_ADD2: alu_lo = y_q + bus;
                OP_SUB:          alu_lo = y_q - bus;
                OP_AND, OP_AND2: alu_lo = y_q & bus;
                OP_OR, OP_OR2:   alu_lo = y_q | bus;
                OP_ROR:          alu_lo = (y_q >> sh) | (y_q << sh_inv);
                OP_ROL:          alu_lo = (y_q << sh) | (y_q >> sh_inv);
                OP_SHR:          alu_lo = y_q >> sh;
                OP_SHRA:         alu_lo = $signed(y_q) >>> sh;
                OP_SHL:          alu_lo = y_q << sh;
                OP_NEG:          alu_lo = -bus;
                OP_NOT:          alu_lo = ~bus;
                default:         alu_lo = bus;
            endcase
        end
        alu = {{32{alu_lo[31]}}, alu_lo};
        if (!IncPC && opcode == OP_MUL) alu = prod;
        if (!IncPC && opcode == OP_DIV) alu = {rem, quo};
    end

    always_comb begin
        case (ir_q[20:19])
            2'b00:   cond = (bus == 32'h0);
            2'b01:   cond = (bus != 32'h0);
            2'b10:   cond = !bus[31] && (bus != 32'h0);
            default: cond = bus[31];
        endcase
        ir_d      = IRin      ? bus : ir_q;
        mar_d     = MARin     ? bus : mar_q;
        y_d       = Yin       ? bus : y_q;
        hi_d      = HIin      ? bus : hi_q;
        lo_d      = LOin      ? bus : lo_q;
        outport_d = OutPortin ? bus : outport_q;
        con_d     = CONin     ? cond : con_q;
        mdr_d     = mdr_q;
        if (MDRin) mdr_d = Read ? mem_rdata : bus;
        z_d       = z_q;
        if (ZLowIn)  z_d[31:0]  = alu[31:0];
        if (ZHighIn) z_d[63:32] = alu[63:32];
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            ir_q <= '0; mar_q <= '0; mdr_q <= '0; y_q <= '0; z_q <= '0;
            hi_q <= '0; lo_q <= '0; outport_q <= '0; con_q <= 1'b0;
        end else begin
            ir_q <= ir_d; mar_q <= mar_d; mdr_q <= mdr_d; y_q <= y_d; z_q <= z_d;
            hi_q <= hi_d; lo_q <= lo_d; outport_q <= outport_d; con_q <= con_d;
        end
    end

    assign CON_out     = con_q;
    assign OutPortData = outport_q;

`ifdef EXT_MEM_EN
    logic unused_ok;
    assign mem_rdata = Mdatain;
    assign unused_ok = ^{Address, Write, mar_q, ir_q[31:27]};
`else
    logic [31:0] ram [MEM_DEPTH];
    logic        unused_ok;

    // RAM contents deliberately survive clear.
    always_ff @(posedge clock) begin
        if (Write) ram[mar_q[AW-1:0]] <= mdr_q;
    end

    assign mem_rdata = ram[mar_q[AW-1:0]];
    assign unused_ok = ^{Address, Mdatain, mar_q[31:AW], ir_q[31:27]};
`endif
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: ALU vector table plus hand-written LDI, CON, bus and clear sequences.
module tb_data_path;
    logic        clock = 1'b0;
    logic        clear;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin;
    logic        IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0]  opcode;
    logic [8:0]  Address;
    logic [31:0] Mdatain, InPortData, OutPortData;
    logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic        CON_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
        .LOout(LOout), .Yout(Yout), .InPortout(InPortout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Rin(Rin), .CONin(CONin), .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .opcode(opcode), .Address(Address), .Mdatain(Mdatain), .InPortData(InPortData),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
        .R6out(R6out), .R7out(R7out), .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
        .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
        .CON_out(CON_out), .OutPortData(OutPortData)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        inc;
        logic [4:0]  op;
        logic [31:0] y;
        logic [31:0] b;
        logic [63:0] z;
    } vec_t;

    vec_t vecs[21];

    task automatic idle();
        clear = 0;
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc} = '0;
        opcode = '0; Address = '0; Mdatain = '0; InPortData = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive_in(input logic [31:0] v);
        InPortData = v;
        InPortout  = 1;
    endtask

    task automatic set_ir(input logic [31:0] v);
        drive_in(v); IRin = 1; tick();
    endtask

    task automatic set_reg(input logic [3:0] k, input logic [31:0] v);
        set_ir({5'd0, k, 23'd0});
        drive_in(v); Gra = 1; Rin = 1; tick();
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] v);
        drive_in(addr); MARin = 1; tick();
        drive_in(v);    MDRin = 1; tick();
        Write = 1; tick();
    endtask

    task automatic ldi();
        PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; tick();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick();
        MDRout = 1; IRin = 1; tick();
        Grb = 1; BAout = 1; Yin = 1; tick();
        Cout = 1; opcode = 5'b00011; ZLowIn = 1; tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'b10000, 32'd7,          32'd6,          64'd42};
        vecs[1]  = '{1'b0, 5'b01111, 32'd17,         32'd5,          64'h00000002_00000003};
        vecs[2]  = '{1'b0, 5'b01111, 32'hFFFFFFF8,   32'd3,          64'hFFFFFFFE_FFFFFFFE};
        vecs[3]  = '{1'b0, 5'b01111, 32'd17,         32'd0,          64'h0};
        vecs[4]  = '{1'b0, 5'b01010, 32'h80000001,   32'd4,          64'hFFFFFFFF_F8000000};
        vecs[5]  = '{1'b0, 5'b00111, 32'h80000001,   32'd4,          64'h00000000_18000000};
        vecs[6]  = '{1'b0, 5'b01011, 32'h80000001,   32'd4,          64'h00000000_00000010};
        vecs[7]  = '{1'b0, 5'b01000, 32'h80000001,   32'd4,          64'h00000000_00000018};
        vecs[8]  = '{1'b0, 5'b01001, 32'h80000001,   32'd4,          64'h00000000_08000000};
        vecs[9]  = '{1'b0, 5'b00100, 32'd5,          32'd7,          64'hFFFFFFFF_FFFFFFFE};
        vecs[10] = '{1'b0, 5'b00101, 32'h0000F0F0,   32'h0000FF00,   64'h00000000_0000F000};
        vecs[11] = '{1'b0, 5'b01110, 32'h0000F0F0,   32'h0000FF00,   64'h00000000_0000FFF0};
        vecs[12] = '{1'b0, 5'b10001, 32'd0,          32'd5,          64'hFFFFFFFF_FFFFFFFB};
        vecs[13] = '{1'b0, 5'b10010, 32'd0,          32'd0,          64'hFFFFFFFF_FFFFFFFF};
        vecs[14] = '{1'b0, 5'b10000, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1};
        vecs[15] = '{1'b0, 5'b00000, 32'd0,          32'h12345678,   64'h00000000_12345678};
        vecs[16] = '{1'b0, 5'b01100, 32'hFFFFFFFF,   32'd1,          64'h0};
        vecs[17] = '{1'b1, 5'b00100, 32'd100,        32'd9,          64'd10};
        vecs[18] = '{1'b0, 5'b00011, 32'h7FFFFFFF,   32'd1,          64'hFFFFFFFF_80000000};
        vecs[19] = '{1'b0, 5'b01101, 32'hAAAA5555,   32'hFFFF0000,   64'hFFFFFFFF_AAAA0000};
        vecs[20] = '{1'b0, 5'b00111, 32'h12345678,   32'd0,          64'h00000000_12345678};

        idle();
        clear = 1; tick();
        chk("rst_pc",  {32'h0, dut.PC_inst.newPC}, 64'h0);
        chk("rst_ir",  {32'h0, dut.ir_q}, 64'h0);
        chk("rst_z",   dut.z_q, 64'h0);
        chk("rst_r5",  {32'h0, dut.r5.BusMuxIn}, 64'h0);
        chk("rst_out", {32'h0, OutPortData}, 64'h0);
        chk("rst_con", {63'h0, CON_out}, 64'h0);

        // LDI R2, 0x95(R2) with R2=0x78
        set_reg(4'd2, 32'h78);
        mem_write(32'd3, 32'h09100095);
        drive_in(32'd3); PCin = 1; tick();
        ldi();
        chk("ldi_pc", {32'h0, dut.PC_inst.newPC}, 64'd4);
        chk("ldi_ir", {32'h0, dut.ir_q}, 64'h09100095);
        chk("ldi_r2", {32'h0, dut.r2.BusMuxIn}, 64'h10D);

        // LDI R2, 0x95(R0): base R0 reads as zero
        set_reg(4'd0, 32'h55);
        set_reg(4'd2, 32'h0);
        mem_write(32'd2, 32'h09000095);
        drive_in(32'd2); PCin = 1; tick();
        ldi();
        chk("ldi0_r2", {32'h0, dut.r2.BusMuxIn}, 64'h95);
        chk("ldi0_pc", {32'h0, dut.PC_inst.newPC}, 64'd3);
        chk("ldi0_r0", {32'h0, dut.r0.BusMuxIn}, 64'h55);

        for (int i = 0; i < 21; i++) begin
            drive_in(vecs[i].y); Yin = 1; tick();
            drive_in(vecs[i].b); opcode = vecs[i].op; IncPC = vecs[i].inc;
            ZLowIn = 1; ZHighIn = 1; tick();
            chk($sformatf("alu%0d", i), dut.z_q, vecs[i].z);
        end

        set_ir(32'h0);
        drive_in(32'd0); CONin = 1; tick();
        chk("con_eq0", {63'h0, CON_out}, 64'd1);
        set_ir(32'h3 << 19);
        drive_in(32'd5); CONin = 1; tick();
        chk("con_neg", {63'h0, CON_out}, 64'd0);
        set_ir(32'h1 << 19);
        drive_in(32'd5); CONin = 1; tick();
        chk("con_ne0", {63'h0, CON_out}, 64'd1);
        set_ir(32'h2 << 19);
        drive_in(32'h80000000); CONin = 1; tick();
        chk("con_pos", {63'h0, CON_out}, 64'd0);

        // bus priority, empty bus, R0 via Rout vs BAout, decode outputs
        drive_in(32'hAA); MDRin = 1; tick();
        PCout = 1; MDRout = 1; Yout = 1; OutPortin = 1; tick();
        chk("bus_prio", {32'h0, OutPortData}, 64'hAA);
        OutPortin = 1; tick();
        chk("bus_none", {32'h0, OutPortData}, 64'h0);
        set_ir(32'h0);
        Gra = 1; Rout = 1; OutPortin = 1; tick();
        chk("rout_r0", {32'h0, OutPortData}, 64'h55);
        Gra = 1; BAout = 1; OutPortin = 1; tick();
        chk("baout_r0", {32'h0, OutPortData}, 64'h0);
        set_ir(32'h5 << 19);
        Grb = 1; Rout = 1; #1;
        chk("rsel_b5", {48'h0, R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                        R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out}, 64'h0020);
        idle();

        // store, read back, then clear mid-instruction
        mem_write(32'h10, 32'hDEAD);
        drive_in(32'h1234); MDRin = 1; tick();
        Read = 1; MDRin = 1; tick();
        chk("mem_rd", {32'h0, dut.mdr_q}, 64'hDEAD);
        set_reg(4'd1, 32'h11);
        set_reg(4'd15, 32'hFF);
        drive_in(32'hCAFE); OutPortin = 1; tick();
        drive_in(32'h77); ZLowIn = 1; ZHighIn = 1; tick();
        drive_in(32'h77); PCin = 1; Gra = 1; Rin = 1; IRin = 1; clear = 1; tick();
        chk("clr_pc",  {32'h0, dut.PC_inst.newPC}, 64'h0);
        chk("clr_ir",  {32'h0, dut.ir_q}, 64'h0);
        chk("clr_z",   dut.z_q, 64'h0);
        chk("clr_out", {32'h0, OutPortData}, 64'h0);
        for (int k = 1; k < 16; k++)
            chk($sformatf("clr_r%0d", k), {32'h0, dut.r_val[k]}, 64'h0);
        drive_in(32'h10); MARin = 1; tick();
        Read = 1; MDRin = 1; tick();
        chk("mem_keep", {32'h0, dut.mdr_q}, 64'hDEAD);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
